// File: rtl/btle_trx_sequencer_if.sv
// Command, status and PHY control bundle between btle_ll / btle_phy and the TRX sequencer.
// master: link layer + PHY side; slave: the sequencer.
interface btle_trx_sequencer_if;
    logic       cmd_start;
    logic [1:0] cmd_mode;
    logic       cmd_abort;
    logic       cmd_ready;
    logic       busy;
    logic       tx_cfg_load;
    logic       tx_start;
    logic       tx_done;
    logic       rx_enable;
    logic       rx_hit_flag;
    logic       rx_decode_end;
    logic       rx_crc_ok;
    logic       done;
    logic [2:0] status;

    modport master (
        output cmd_start, cmd_mode, cmd_abort, tx_done, rx_hit_flag, rx_decode_end, rx_crc_ok,
        input  cmd_ready, busy, tx_cfg_load, tx_start, rx_enable, done, status
    );

    modport slave (
        input  cmd_start, cmd_mode, cmd_abort, tx_done, rx_hit_flag, rx_decode_end, rx_crc_ok,
        output cmd_ready, busy, tx_cfg_load, tx_start, rx_enable, done, status
    );
endinterface

// File: rtl/btle_trx_sequencer.sv
// Sequences one BTLE PHY transaction (TX, RX, TX->RX, RX->TX-on-CRC-ok) with T_IFS timing,
// RX listen window and TX / RX-decode watchdogs; reports one status code per transaction.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// IDLE        | waiting for cmd_start, cmd_ready high
// TX_LOAD     | one-cycle tx_cfg_load strobe to the PHY
// TX_START    | one-cycle tx_start strobe to the PHY
// TX_WAIT     | waiting for tx_done, TX watchdog running
// IFS         | inter-frame space before the pending phase (RX or TX reply)
// RX_LISTEN   | rx_enable high, waiting for access-address hit within window
// RX_DECODE   | rx_enable high, waiting for rx_decode_end, decode watchdog running
// DONE        | one-cycle done pulse, status just updated
module btle_trx_sequencer #(
    parameter int CLK_FREQUENCE        = 16_000_000,
    parameter int T_IFS_US             = 150,
    parameter int RX_WINDOW_US         = 500,
    parameter int TX_TIMEOUT_US        = 2200,
    parameter int RX_DECODE_TIMEOUT_US = 2200
) (
    input  logic                  clk,
    input  logic                  rst,
    btle_trx_sequencer_if.slave   bus
);

    localparam int CYC_PER_US = CLK_FREQUENCE / 1_000_000;
    localparam int IFS_CYC    = T_IFS_US * CYC_PER_US;
    localparam int WIN_CYC    = RX_WINDOW_US * CYC_PER_US;
    localparam int TXTO_CYC   = TX_TIMEOUT_US * CYC_PER_US;
    localparam int DECTO_CYC  = RX_DECODE_TIMEOUT_US * CYC_PER_US;

    localparam int MAX_A   = (IFS_CYC > WIN_CYC) ? IFS_CYC : WIN_CYC;
    localparam int MAX_B   = (TXTO_CYC > DECTO_CYC) ? TXTO_CYC : DECTO_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] IFS_LAST   = CNT_W'(IFS_CYC - 1);
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0] TXTO_LAST  = CNT_W'(TXTO_CYC - 1);
    localparam logic [CNT_W-1:0] DECTO_LAST = CNT_W'(DECTO_CYC - 1);

    localparam logic [1:0] MODE_TX    = 2'b00;
    localparam logic [1:0] MODE_TX_RX = 2'b10;
    localparam logic [1:0] MODE_RX_TX = 2'b11;

    localparam logic [2:0] ST_OK         = 3'd0;
    localparam logic [2:0] ST_RX_TIMEOUT = 3'd1;
    localparam logic [2:0] ST_CRC_FAIL   = 3'd2;
    localparam logic [2:0] ST_TX_TIMEOUT = 3'd3;
    localparam logic [2:0] ST_ABORTED    = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        TX_LOAD,
        TX_START,
        TX_WAIT,
        IFS,
        RX_LISTEN,
        RX_DECODE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       mode_q;
    logic [1:0]       mode_nxt;
    logic [2:0]       status_q;
    logic [2:0]       status_nxt;
    logic [CNT_W-1:0] cnt;

    logic cmd_ready_q;
    logic busy_q;
    logic tx_cfg_load_q;
    logic tx_start_q;
    logic rx_enable_q;
    logic done_q;

    always_comb begin
        state_nxt  = state;
        mode_nxt   = mode_q;
        status_nxt = status_q;
        case (state)
            IDLE: begin
                if (bus.cmd_start) begin
                    mode_nxt  = bus.cmd_mode;
                    state_nxt = bus.cmd_mode[0] ? RX_LISTEN : TX_LOAD;
                end
            end
            TX_LOAD:  state_nxt = TX_START;
            TX_START: state_nxt = TX_WAIT;
            TX_WAIT: begin
                if (bus.tx_done) begin
                    if (mode_q == MODE_TX_RX) begin
                        state_nxt = IFS;
                    end else begin
                        state_nxt  = DONE;
                        status_nxt = ST_OK;
                    end
                end else if (cnt == TXTO_LAST) begin
                    state_nxt  = DONE;
                    status_nxt = ST_TX_TIMEOUT;
                end
            end
            // Only modes 10 and 11 pass through IFS; the mode picks the pending phase.
            IFS: begin
                if (cnt == IFS_LAST) begin
                    state_nxt = (mode_q == MODE_TX_RX) ? RX_LISTEN : TX_LOAD;
                end
            end
            RX_LISTEN: begin
                if (bus.rx_hit_flag) begin
                    state_nxt = RX_DECODE;
                end else if (cnt == WIN_LAST) begin
                    state_nxt  = DONE;
                    status_nxt = ST_RX_TIMEOUT;
                end
            end
            RX_DECODE: begin
                if (bus.rx_decode_end) begin
                    if ((mode_q == MODE_RX_TX) && bus.rx_crc_ok) begin
                        state_nxt = IFS;
                    end else begin
                        state_nxt  = DONE;
                        status_nxt = bus.rx_crc_ok ? ST_OK : ST_CRC_FAIL;
                    end
                end else if (cnt == DECTO_LAST) begin
                    state_nxt  = DONE;
                    status_nxt = ST_RX_TIMEOUT;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (bus.cmd_abort && (state != IDLE) && (state != DONE)) begin
            state_nxt  = DONE;
            status_nxt = ST_ABORTED;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            mode_q        <= MODE_TX;
            status_q      <= ST_OK;
            cnt           <= '0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            tx_cfg_load_q <= 1'b0;
            tx_start_q    <= 1'b0;
            rx_enable_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state    <= state_nxt;
            mode_q   <= mode_nxt;
            status_q <= status_nxt;
            // Counter measures time spent in the current state; idle time is not counted.
            if ((state_nxt != state) || (state == IDLE) || (state == DONE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            cmd_ready_q   <= (state_nxt == IDLE);
            busy_q        <= (state_nxt != IDLE);
            tx_cfg_load_q <= (state_nxt == TX_LOAD);
            tx_start_q    <= (state_nxt == TX_START);
            rx_enable_q   <= (state_nxt == RX_LISTEN) || (state_nxt == RX_DECODE);
            done_q        <= (state_nxt == DONE);
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.busy        = busy_q;
    assign bus.tx_cfg_load = tx_cfg_load_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.rx_enable   = rx_enable_q;
    assign bus.done        = done_q;
    assign bus.status      = status_q;

endmodule

// File: doc/btle_trx_sequencer.md
Name: btle_trx_sequencer

Overview:
Link-layer-side scheduler that sequences one BTLE PHY transaction: TX only, RX only, TX followed by RX, or RX followed by a conditional TX reply. It issues the PHY TX load/start strobes, times the inter-frame space (T_IFS), gates the receiver with an RX listen window, and applies TX and RX watchdogs. It sits between btle_ll command decode and the btle_phy tx_start / *_load / rx control pins, and reports one status code per transaction.

Parameters:
CLK_FREQUENCE, 16_000_000, clock frequency in Hz; CYC_PER_US = CLK_FREQUENCE/1_000_000 (integer).
T_IFS_US, 150, TX-end/RX-end to next-phase start gap, in µs.
RX_WINDOW_US, 500, maximum wait for rx_hit_flag after rx_enable rises, in µs.
TX_TIMEOUT_US, 2200, maximum wait for tx_done after tx_start, in µs.
RX_DECODE_TIMEOUT_US, 2200, maximum wait for rx_decode_end after a hit, in µs.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cmd_start  in  1  transaction request; accepted only when cmd_ready=1
cmd_mode  in  2  00 TX only, 01 RX only, 10 TX→RX, 11 RX→TX-on-CRC-ok; sampled on accept
cmd_abort  in  1  abort current transaction
cmd_ready  out  1  high in IDLE only
busy  out  1  high whenever state≠IDLE
tx_cfg_load  out  1  one-cycle pulse; drives phy tx_crc_state_init_bit_load and tx_channel_number_load
tx_start  out  1  one-cycle pulse to phy
tx_done  in  1  phy TX end (tx_iq_valid_last)
rx_enable  out  1  receiver gate, high in RX_LISTEN and RX_DECODE
rx_hit_flag  in  1  phy access-address hit
rx_decode_end  in  1  phy packet decode complete
rx_crc_ok  in  1  phy CRC result, valid with rx_decode_end
done  out  1  one-cycle transaction-complete pulse
status  out  3  result, held from done until the next accept: 0 OK, 1 RX_TIMEOUT, 2 CRC_FAIL, 3 TX_TIMEOUT, 4 ABORTED

Behaviour:
- Reset (rst=0, async): state=IDLE; cmd_ready=1; busy, tx_cfg_load, tx_start, rx_enable, done=0; status=0; all counters=0. Reset mid-transaction drops strobes and rx_enable immediately.
- States: IDLE, TX_LOAD, TX_START, TX_WAIT, IFS, RX_LISTEN, RX_DECODE, DONE. Registered outputs are decoded from state: tx_cfg_load=(TX_LOAD); tx_start=(TX_START); done=(DONE).
- IDLE: on cmd_start, latch mode. Modes 00/10 go to TX_LOAD; modes 01/11 go to RX_LISTEN. cmd_start outside IDLE is ignored.
- TX_LOAD: 1 cycle, then TX_START. TX_START: 1 cycle, then TX_WAIT. tx_start is high exactly 2 cycles after the accept edge.
- TX_WAIT: tx_done is counted only in this state. Mode 10 on tx_done → IFS (next phase RX). Modes 00/11 on tx_done → DONE, status=0. If TX_TIMEOUT_US*CYC_PER_US cycles pass with no tx_done → DONE, status=3.
- IFS: count T_IFS_US*CYC_PER_US cycles (2400 at defaults), then enter the pending phase (RX_LISTEN or TX_LOAD). The counter is cleared on entry.
- RX_LISTEN: rx_hit_flag → RX_DECODE. Window expiry (RX_WINDOW_US*CYC_PER_US cycles) → DONE, status=1. Hit and expiry in the same cycle: hit wins.
- RX_DECODE: on rx_decode_end, mode 11 with rx_crc_ok=1 → IFS (next phase TX). Otherwise, rx_crc_ok=1 → DONE status=0 and rx_crc_ok=0 → DONE status=2. If the decode watchdog expires → DONE, status=1. decode_end and watchdog in the same cycle: decode_end wins. rx_decode_end in RX_LISTEN is ignored.
- DONE: 1 cycle, then IDLE. status updates on DONE entry.
- cmd_abort: highest priority in any non-IDLE, non-DONE state → DONE with status=4 next cycle. Ignored in IDLE and DONE.
- Counters: one shared up-counter, width $clog2(max cycle limit)+1. It clears on every state change. Expiry is the comparison count==limit-1.
- The receiver never sees rx_enable during TX states. There is no overlap of tx_start and rx_enable.

Test Plan:
- Mode 00, tx_done 100 cycles after tx_start → tx_cfg_load at accept+1, tx_start at accept+2, done 1 cycle after tx_done, status=0, rx_enable never high.
- Mode 10 with tx_done → rx_enable rises exactly 2400 cycles after tx_done. Hit at +50, rx_decode_end with crc_ok=1 → done, status=0, rx_enable falls with DONE.
- Mode 01 with no hit → rx_enable high for exactly 8000 cycles, then done with status=1. Repeat with hit and expiry in the same cycle → RX_DECODE entered, no timeout.
- Mode 11 with decode_end, crc_ok=1 → tx_start 2400+2 cycles later, done after tx_done, status=0. Repeat with crc_ok=0 → done, status=2, no tx_start.
- Mode 00 with tx_done withheld → done after 35200 cycles, status=3. cmd_start during busy → ignored, cmd_ready=0.
- cmd_abort in IFS → done next cycle, status=4. Async rst low mid-RX_LISTEN → rx_enable=0 immediately, cmd_ready=1 after release.
